// File: rtl/legv8_decode_execute.sv
// LEGv8 core slice: main-control decode (ID), ID/EX control register, ALU-control decode and 64-bit ALU (EX).
// Optional feature macro LEGV8_EOR_EN: adds EOR (11001010000) as an R-type op computing A^B (ALU code 0011).
module legv8_decode_execute #(
   parameter int XLEN  = 64,
   parameter int OPC_W = 11
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [OPC_W-1:0] id_opcode,
   input  logic             id_stall,
   input  logic [XLEN-1:0]  ex_a,
   input  logic [XLEN-1:0]  ex_b,
   output logic             id_reg2loc,
   output logic             id_alusrc,
   output logic             id_stop_fetch,
   output logic             ex_alusrc,
   output logic             ex_branch_z,
   output logic             ex_branch_nz,
   output logic             ex_uncond,
   output logic             ex_mem_read,
   output logic             ex_mem_write,
   output logic             ex_reg_write,
   output logic             ex_mem2reg,
   output logic [1:0]       ex_aluop,
   output logic [OPC_W-1:0] ex_opcode,
   output logic [3:0]       alu_ctrl,
   output logic [XLEN-1:0]  alu_result,
   output logic             alu_zero
);

   localparam logic [OPC_W-1:0] OP_HALT = 11'b11111111111;
   localparam logic [OPC_W-1:0] OP_LDUR = 11'b11111000010;
   localparam logic [OPC_W-1:0] OP_STUR = 11'b11111000000;
   localparam logic [OPC_W-1:0] OP_ADD  = 11'b10001011000;
   localparam logic [OPC_W-1:0] OP_SUB  = 11'b11001011000;
   localparam logic [OPC_W-1:0] OP_AND  = 11'b10001010000;
   localparam logic [OPC_W-1:0] OP_ORR  = 11'b10101010000;
   localparam logic [OPC_W-1:0] OP_EOR  = 11'b11001010000;

   // Control word order: {alusrc, bz, bnz, ub, memrd, memwr, regwr, mem2reg, aluop[1:0]}
   logic [9:0] id_ctl;
   logic [9:0] ctl_d, ctl_q;
   logic [OPC_W-1:0] opc_d, opc_q;

   always_comb begin
      id_ctl        = '0;
      id_reg2loc    = 1'b0;
      id_stop_fetch = 1'b0;
      if (id_opcode == OP_HALT) begin
         id_stop_fetch = 1'b1;
      end else if (id_opcode == OP_LDUR) begin
         id_ctl = 10'b1000101100;
      end else if (id_opcode == OP_STUR) begin
         id_ctl     = 10'b1000010000;
         id_reg2loc = 1'b1;
      end else if (id_opcode == OP_ADD || id_opcode == OP_SUB ||
                   id_opcode == OP_AND || id_opcode == OP_ORR) begin
         id_ctl = 10'b0000001010;
`ifdef LEGV8_EOR_EN
      end else if (id_opcode == OP_EOR) begin
         id_ctl = 10'b0000001010;
`endif
      end else if (id_opcode[10:1] == 10'b1001000100) begin
         id_ctl = 10'b1000001010;
      end else if (id_opcode[10:3] == 8'b10110100) begin
         id_ctl     = 10'b0100000001;
         id_reg2loc = 1'b1;
      end else if (id_opcode[10:3] == 8'b10110101) begin
         id_ctl     = 10'b0010000001;
         id_reg2loc = 1'b1;
      end else if (id_opcode[10:5] == 6'b000101) begin
         id_ctl = 10'b0001000000;
      end
   end

   assign id_alusrc = id_ctl[9];

   // A stall turns the EX stage into a bubble: no controls, zero opcode.
   assign ctl_d = id_stall ? '0 : id_ctl;
   assign opc_d = id_stall ? '0 : id_opcode;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ctl_q <= '0;
         opc_q <= '0;
      end else begin
         ctl_q <= ctl_d;
         opc_q <= opc_d;
      end
   end

   assign {ex_alusrc, ex_branch_z, ex_branch_nz, ex_uncond, ex_mem_read,
           ex_mem_write, ex_reg_write, ex_mem2reg, ex_aluop} = ctl_q;
   assign ex_opcode = opc_q;

   always_comb begin
      alu_ctrl = 4'b0010;
      case (ex_aluop)
         2'b01: alu_ctrl = 4'b0111;
         2'b10: begin
            if (ex_opcode == OP_SUB)      alu_ctrl = 4'b0110;
            else if (ex_opcode == OP_AND) alu_ctrl = 4'b0000;
            else if (ex_opcode == OP_ORR) alu_ctrl = 4'b0001;
`ifdef LEGV8_EOR_EN
            else if (ex_opcode == OP_EOR) alu_ctrl = 4'b0011;
`endif
            else                          alu_ctrl = 4'b0010;
         end
         default: alu_ctrl = 4'b0010;
      endcase
   end

   always_comb begin
      alu_result = '0;
      case (alu_ctrl)
         4'b0000: alu_result = ex_a & ex_b;
         4'b0001: alu_result = ex_a | ex_b;
         4'b0010: alu_result = ex_a + ex_b;
`ifdef LEGV8_EOR_EN
         4'b0011: alu_result = ex_a ^ ex_b;
`endif
         4'b0110: alu_result = ex_a - ex_b;
         4'b0111: alu_result = ex_b;
         4'b1100: alu_result = ~(ex_a | ex_b);
         default: alu_result = '0;
      endcase
   end

   assign alu_zero = (alu_result == '0);

endmodule

// File: tb/tb_legv8_decode_execute.sv
// Directed bench for legv8_decode_execute: decode, ID/EX register, stall bubble, async reset, ALU.
module tb_legv8_decode_execute;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [10:0] id_opcode;
   logic        id_stall;
   logic [63:0] ex_a, ex_b;
   logic        id_reg2loc, id_alusrc, id_stop_fetch;
   logic        ex_alusrc, ex_branch_z, ex_branch_nz, ex_uncond;
   logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_mem2reg;
   logic [1:0]  ex_aluop;
   logic [10:0] ex_opcode;
   logic [3:0]  alu_ctrl;
   logic [63:0] alu_result;
   logic        alu_zero;

   int tests_run = 0;
   int fails     = 0;

   // {alusrc, bz, bnz, ub, memrd, memwr, regwr, mem2reg, aluop}
   wire [9:0] ex_ctl = {ex_alusrc, ex_branch_z, ex_branch_nz, ex_uncond, ex_mem_read,
                        ex_mem_write, ex_reg_write, ex_mem2reg, ex_aluop};
   wire [2:0] id_ctl = {id_reg2loc, id_alusrc, id_stop_fetch};

   legv8_decode_execute dut (
      .clock(clock), .reset_n(reset_n), .id_opcode(id_opcode), .id_stall(id_stall),
      .ex_a(ex_a), .ex_b(ex_b),
      .id_reg2loc(id_reg2loc), .id_alusrc(id_alusrc), .id_stop_fetch(id_stop_fetch),
      .ex_alusrc(ex_alusrc), .ex_branch_z(ex_branch_z), .ex_branch_nz(ex_branch_nz),
      .ex_uncond(ex_uncond), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_reg_write(ex_reg_write), .ex_mem2reg(ex_mem2reg), .ex_aluop(ex_aluop),
      .ex_opcode(ex_opcode), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic load(input logic [10:0] opc, input logic stall);
      id_opcode = opc;
      id_stall  = stall;
      tick();
   endtask

   initial begin
      reset_n   = 1'b0;
      id_opcode = 11'h7C2;
      id_stall  = 1'b0;
      ex_a      = 64'h0;
      ex_b      = 64'h0;
      tick();
      check("reset_ctl", {54'h0, ex_ctl}, 64'h0);
      check("reset_opc", {53'h0, ex_opcode}, 64'h0);
      check("reset_alu_ctrl", {60'h0, alu_ctrl}, 64'h2);
      reset_n = 1'b1;

      // Combinational ID decode
      id_opcode = 11'h7FF; #1;
      check("halt_id", {61'h0, id_ctl}, 64'b001);
      id_opcode = 11'h000; #1;
      check("nop_id", {61'h0, id_ctl}, 64'b000);
      id_opcode = 11'h7C0; #1;
      check("stur_id", {61'h0, id_ctl}, 64'b110);

      // LDUR into EX
      ex_a = 64'h10; ex_b = 64'h8;
      load(11'h7C2, 1'b0);
      check("ldur_ctl", {54'h0, ex_ctl}, 64'b1000101100);
      check("ldur_opc", {53'h0, ex_opcode}, 64'h7C2);
      check("ldur_alu_ctrl", {60'h0, alu_ctrl}, 64'h2);
      check("ldur_result", alu_result, 64'h18);
      check("ldur_zero", {63'h0, alu_zero}, 64'h0);

      // Asynchronous reset mid-cycle with LDUR in EX
      ex_a = 64'h5; ex_b = 64'hFFFF_FFFF_FFFF_FFFB;
      #2 reset_n = 1'b0;
      #1;
      check("arst_ctl", {54'h0, ex_ctl}, 64'h0);
      check("arst_opc", {53'h0, ex_opcode}, 64'h0);
      check("arst_alu_ctrl", {60'h0, alu_ctrl}, 64'h2);
      check("arst_zero", {63'h0, alu_zero}, 64'h1);
      #1 reset_n = 1'b1;

      // SUB equal operands
      ex_a = 64'd5; ex_b = 64'd5;
      load(11'h658, 1'b0);
      check("sub_ctl", {54'h0, ex_ctl}, 64'b0000001010);
      check("sub_alu_ctrl", {60'h0, alu_ctrl}, 64'h6);
      check("sub_result", alu_result, 64'h0);
      check("sub_zero", {63'h0, alu_zero}, 64'h1);

      // ADDI with negative immediate
      ex_a = 64'd7; ex_b = 64'hFFFF_FFFF_FFFF_FFFF;
      load(11'h489, 1'b0);
      check("addi_ctl", {54'h0, ex_ctl}, 64'b1000001010);
      check("addi_result", alu_result, 64'd6);

      // CBZ pass-B behaviour
      ex_a = 64'h1234; ex_b = 64'h0;
      id_opcode = 11'h5A3; #1;
      check("cbz_id", {61'h0, id_ctl}, 64'b100);
      load(11'h5A3, 1'b0);
      check("cbz_ctl", {54'h0, ex_ctl}, 64'b0100000001);
      check("cbz_alu_ctrl", {60'h0, alu_ctrl}, 64'h7);
      check("cbz_zero_b0", {63'h0, alu_zero}, 64'h1);
      ex_b = 64'd3; #1;
      check("cbz_zero_b3", {63'h0, alu_zero}, 64'h0);
      check("cbz_result_b3", alu_result, 64'd3);

      // CBNZ, B, STUR
      load(11'h5AF, 1'b0);
      check("cbnz_ctl", {54'h0, ex_ctl}, 64'b0010000001);
      load(11'h0A5, 1'b0);
      check("b_ctl", {54'h0, ex_ctl}, 64'b0001000000);
      ex_a = 64'h100; ex_b = 64'h20;
      load(11'h7C0, 1'b0);
      check("stur_ctl", {54'h0, ex_ctl}, 64'b1000010000);
      check("stur_result", alu_result, 64'h120);

      // Stall bubble, then ADD on the next unstalled edge
      ex_a = 64'd3; ex_b = 64'd4;
      load(11'h458, 1'b1);
      check("stall_ctl", {54'h0, ex_ctl}, 64'h0);
      check("stall_opc", {53'h0, ex_opcode}, 64'h0);
      load(11'h458, 1'b0);
      check("add_ctl", {54'h0, ex_ctl}, 64'b0000001010);
      check("add_opc", {53'h0, ex_opcode}, 64'h458);
      check("add_result", alu_result, 64'd7);

      // AND / ORR
      ex_a = 64'hF0F0_0000_FFFF_0001; ex_b = 64'h0FF0_0000_00FF_0003;
      load(11'h450, 1'b0);
      check("and_alu_ctrl", {60'h0, alu_ctrl}, 64'h0);
      check("and_result", alu_result, 64'h00F0_0000_00FF_0001);
      load(11'h550, 1'b0);
      check("orr_alu_ctrl", {60'h0, alu_ctrl}, 64'h1);
      check("orr_result", alu_result, 64'hFFF0_0000_FFFF_0003);

      // EOR depends on build configuration
      load(11'h650, 1'b0);
`ifdef LEGV8_EOR_EN
      check("eor_ctl", {54'h0, ex_ctl}, 64'b0000001010);
      check("eor_alu_ctrl", {60'h0, alu_ctrl}, 64'h3);
      check("eor_result", alu_result, 64'hFF00_0000_FF00_0002);
`else
      check("eor_ctl", {54'h0, ex_ctl}, 64'h0);
      check("eor_alu_ctrl", {60'h0, alu_ctrl}, 64'h2);
      check("eor_result", alu_result, 64'h00E0_0001_00FE_0004);
`endif

      // Unlisted opcode and HALT through EX are both empty control words
      load(11'h123, 1'b0);
      check("nop_ctl", {54'h0, ex_ctl}, 64'h0);
      check("nop_opc", {53'h0, ex_opcode}, 64'h123);
      load(11'h7FF, 1'b0);
      check("halt_ctl", {54'h0, ex_ctl}, 64'h0);
      check("halt_stop", {63'h0, id_stop_fetch}, 64'h1);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
